// File: rtl/apb_register_bank.sv
`default_nettype none
// ============================================================================
// apb_register_bank
// ECC accelerator register bank: config/operand registers, start/busy/done
// handshake with the core, read-only result capture. Optional ECC_IRQ_EN
// adds an `interrupt` output mirroring STATUS.done.
// Revision: 1.0
// ============================================================================
module apb_register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            REG_ENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic [1:0]            core_ctrl,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [1:0]            core_cw_width,
  output logic [DATA_WIDTH-1:0] core_noise,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [1:0]            core_num_err
`ifdef ECC_IRQ_EN
  ,
  output logic                  interrupt
`endif
);

  localparam logic [2:0] SEL_CTRL    = 3'd0;
  localparam logic [2:0] SEL_DATA_IN = 3'd1;
  localparam logic [2:0] SEL_CW      = 3'd2;
  localparam logic [2:0] SEL_NOISE   = 3'd3;
  localparam logic [2:0] SEL_DOUT    = 3'd4;
  localparam logic [2:0] SEL_NERR    = 3'd5;
  localparam logic [2:0] SEL_STATUS  = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2} state_t;

  state_t                  state;
  logic [1:0]              reg_en_q;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [1:0]              num_err;
  logic                    done;
  logic                    wr_err;
  logic [2:0]              sel;
  logic                    busy;
  logic                    wr_pulse;
  logic                    rd_pulse;
  logic                    sel_rw;
  logic                    unused_addr;

  assign sel         = PADDR[4:2];
  assign unused_addr = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};
  assign busy        = (state != IDLE);
  // Only the first cycle of an access run acts; a held enable is a no-op.
  assign wr_pulse    = (REG_ENABLE == 2'b01) && (reg_en_q != 2'b01);
  assign rd_pulse    = (REG_ENABLE == 2'b10) && (reg_en_q != 2'b10);
  assign sel_rw      = (sel == SEL_CTRL) || (sel == SEL_DATA_IN) ||
                       (sel == SEL_CW)   || (sel == SEL_NOISE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      reg_en_q      <= 2'b00;
      core_ctrl     <= 2'b00;
      core_data_in  <= '0;
      core_cw_width <= 2'b00;
      core_noise    <= '0;
      core_start    <= 1'b0;
      data_out      <= '0;
      num_err       <= 2'b00;
      done          <= 1'b0;
      wr_err        <= 1'b0;
`ifdef ECC_IRQ_EN
      interrupt     <= 1'b0;
`endif
    end else begin
      reg_en_q   <= REG_ENABLE;
      core_start <= 1'b0;

      if (rd_pulse && (sel == SEL_STATUS)) begin
        done   <= 1'b0;
        wr_err <= 1'b0;
      end

      if (wr_pulse && sel_rw) begin
        if (busy) begin
          wr_err <= 1'b1;
        end else begin
          case (sel)
            SEL_CTRL:    core_ctrl     <= PWDATA[1:0];
            SEL_DATA_IN: core_data_in  <= PWDATA;
            SEL_CW:      core_cw_width <= PWDATA[1:0];
            SEL_NOISE:   core_noise    <= PWDATA;
            default:     ;
          endcase
        end
      end

      // Flag sets follow the clear above so a same-cycle set wins.
      case (state)
        IDLE: begin
          if (wr_pulse && (sel == SEL_CTRL)) begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: state <= BUSY;
        BUSY: begin
          if (core_done) begin
            data_out <= core_data_out;
            num_err  <= core_num_err;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef ECC_IRQ_EN
      interrupt <= done;
`endif
    end
  end

  always_comb begin
    PRDATA = '0;
    if (REG_ENABLE == 2'b10) begin
      case (sel)
        SEL_CTRL:    PRDATA = {{(DATA_WIDTH-2){1'b0}}, core_ctrl};
        SEL_DATA_IN: PRDATA = core_data_in;
        SEL_CW:      PRDATA = {{(DATA_WIDTH-2){1'b0}}, core_cw_width};
        SEL_NOISE:   PRDATA = core_noise;
        SEL_DOUT:    PRDATA = data_out;
        SEL_NERR:    PRDATA = {{(DATA_WIDTH-2){1'b0}}, num_err};
        SEL_STATUS:  PRDATA = {{(DATA_WIDTH-3){1'b0}}, wr_err, done, busy};
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
